rep3_serial_tx: RTL and testbench
=================================

Name: rep3_serial_tx

Overview:
Serial transmitter for the triple-repetition line code. The receive end recovers each bit with a 3-input majority voter built from library majority cells. The block accepts a parallel word over a valid/ready handshake and frames it as one start bit, DATA_W data bits (LSB first) and one stop bit. Each bit is sent as REP identical chips, and each chip lasts BAUD_DIV clock cycles. It sits between core logic and the single-wire link to the majority-voting receiver.

Parameters:
DATA_W, 8, payload width in bits (1..32)
REP, 3, repetitions per bit; odd and at least 1, so the voter at the far end resolves ties
BAUD_DIV, 4, clock cycles per chip; at least 1
IDLE_LVL, 1, line level when idle and for the stop bit; the start bit is ~IDLE_LVL

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
in_data  input  DATA_W  word to transmit; sampled only on accept
in_valid  input  1  producer has a word
in_ready  output  1  block can accept a word
tx_o  output  1  registered serial line
busy  output  1  frame in progress (START/DATA/STOP)
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset and interface: one clock; reset is synchronous and active-high. While rst is high at a clock edge:
  - state goes to IDLE; all counters clear;
  - tx_o = IDLE_LVL, busy = 0, done = 0;
  - in_ready is forced to 0 while rst is high.
  - Reset mid-frame aborts the frame immediately. No stop bit is sent and no done pulse is produced.
- Accept: occurs on the edge where in_valid & in_ready. The shift register loads in_data and the state moves to START.
  - in_ready = (state == IDLE) & ~rst, combinational.
  - in_data is ignored at all other times. Changes in in_data mid-frame have no effect.
- Latency: tx_o shows the first start chip from the edge after accept, i.e. one cycle of latency. busy rises on the same edge.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx_o = IDLE_LVL; wait for accept.
  - START: tx_o = ~IDLE_LVL for REP*BAUD_DIV cycles.
  - DATA: tx_o = shreg[0] for REP*BAUD_DIV cycles per bit. The shift register shifts right after the last chip of each bit, for DATA_W bits in total.
  - STOP: tx_o = IDLE_LVL for REP*BAUD_DIV cycles.
- Counters:
  - div_cnt runs 0..BAUD_DIV-1.
  - rep_cnt runs 0..REP-1 and advances when div_cnt wraps.
  - bit_cnt runs 0..DATA_W-1 and advances when rep_cnt and div_cnt both wrap.
  - Each counter is sized to ceil(log2(max)) bits, minimum 1.
  - Counters clear on every state transition.
- Frame length: exactly (DATA_W+2)*REP*BAUD_DIV cycles of busy = 1.
- done: asserted for one cycle on the edge that leaves STOP, together with state = IDLE and busy = 0. in_ready is 1 in that same cycle.
- Back-to-back frames: a word offered with in_valid held high is accepted in the done cycle. The next start chip then follows after exactly 1 idle cycle at IDLE_LVL. No other gap is inserted.
- Degenerate parameters:
  - REP = 1 and BAUD_DIV = 1 is a plain NRZ serializer, one cycle per bit.
  - No combinational path exists from in_valid to tx_o.
- Illegal parameters: even REP or BAUD_DIV = 0 fails an elaboration-time assertion.

Test Plan:
- Reset and idle: hold rst for 3 cycles with in_valid = 1 -> in_ready = 0, tx_o = 1, busy = 0, done = 0. After release, in_ready = 1 and tx_o stays 1 with no accept during reset.
- Single frame (DATA_W=8, REP=3, BAUD_DIV=2), send 0xA5 -> tx_o sequence starting one cycle after accept:
  - start: 6 cycles of 0;
  - data bits in order 1,0,1,0,0,1,0,1, each held 6 cycles;
  - stop: 6 cycles of 1.
  - busy high for 60 cycles; done pulses once at cycle 61. A 3-chip majority model recovers 0xA5.
- Back-to-back: in_valid held high with 0x00 then 0xFF -> second accept in the done cycle; exactly one idle cycle at 1 between the stop and the next start; both words recovered.
- Handshake stability: toggle in_data every cycle during a frame of 0x3C -> transmitted payload is still 0x3C, and in_ready stays 0 for the whole frame.
- Reset mid-frame: assert rst at cycle 20 of a 60-cycle frame -> tx_o = 1 from the next edge, no done pulse; the following frame of 0x81 transmits correctly.
- Degenerate configuration (REP=1, BAUD_DIV=1, DATA_W=4), send 0x6 -> tx_o = 0,0,1,1,0,1; frame 6 cycles long; done on cycle 7.

Source files
------------

// File: rtl/rep3_serial_tx_if.sv
// rtl/rep3_serial_tx_if.sv - parallel word handshake into the repetition-code transmitter
interface rep3_serial_tx_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/rep3_serial_tx.sv
// rtl/rep3_serial_tx.sv - frames a word as start/data/stop bits, each bit sent as REP chips of BAUD_DIV cycles
module rep3_serial_tx #(
  parameter int   DATA_W   = 8,
  parameter int   REP      = 3,
  parameter int   BAUD_DIV = 4,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  rep3_serial_tx_if.slave s_in,
  output logic            tx_o,
  output logic            busy,
  output logic            done
);
  localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int REP_W = (REP > 1) ? $clog2(REP) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  if ((REP < 1) || ((REP % 2) == 0) || (BAUD_DIV < 1) || (DATA_W < 1) || (DATA_W > 32)) begin : g_bad_params
    $error("rep3_serial_tx: REP must be odd and >= 1, BAUD_DIV >= 1, DATA_W in 1..32");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div;
  logic [REP_W-1:0]  r_rep;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] r_shreg;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_div_wrap;
  logic              w_bit_end;
  logic              w_last_bit;
  logic [DATA_W-1:0] w_shreg_nxt;

  assign s_in.in_ready = (r_state == IDLE) & ~rst;
  assign w_accept      = s_in.in_valid & s_in.in_ready;
  assign w_div_wrap    = (r_div == DIV_W'(BAUD_DIV - 1));
  assign w_bit_end     = w_div_wrap & (r_rep == REP_W'(REP - 1));
  assign w_last_bit    = (r_bit == BIT_W'(DATA_W - 1));
  assign w_shreg_nxt   = r_shreg >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_rep   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_tx    <= IDLE_LVL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Chip timing runs in every non-idle state; the end of a bit always clears div/rep
      if (r_state != IDLE) begin
        if (w_bit_end) begin
          r_div <= '0;
          r_rep <= '0;
        end else if (w_div_wrap) begin
          r_div <= '0;
          r_rep <= r_rep + REP_W'(1);
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= s_in.in_data;
            r_state <= START;
            r_tx    <= ~IDLE_LVL;
            r_busy  <= 1'b1;
            r_div   <= '0;
            r_rep   <= '0;
            r_bit   <= '0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_tx    <= r_shreg[0];
            r_bit   <= '0;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_shreg <= w_shreg_nxt;
            if (w_last_bit) begin
              r_state <= STOP;
              r_tx    <= IDLE_LVL;
              r_bit   <= '0;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
              r_tx  <= w_shreg_nxt[0];
            end
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state <= IDLE;
            r_tx    <= IDLE_LVL;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bit   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_o = r_tx;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_rep3_serial_tx.sv
// tb/tb_rep3_serial_tx.sv - scoreboard bench for rep3_serial_tx, main and NRZ-degenerate configurations
module tb_rep3_serial_tx;
  localparam int DW  = 8;
  localparam int REP = 3;
  localparam int BD  = 2;
  localparam int RB  = REP * BD;
  localparam int NF  = (DW + 2) * RB;
  localparam int DW2 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rep3_serial_tx_if #(.DATA_W(DW))  u_if ();
  rep3_serial_tx_if #(.DATA_W(DW2)) u_if2 ();

  logic tx, busy, done, tx2, busy2, done2;

  rep3_serial_tx #(.DATA_W(DW), .REP(REP), .BAUD_DIV(BD), .IDLE_LVL(1'b1)) u_dut (
    .clk(clk), .rst(rst), .s_in(u_if), .tx_o(tx), .busy(busy), .done(done)
  );

  rep3_serial_tx #(.DATA_W(DW2), .REP(1), .BAUD_DIV(1), .IDLE_LVL(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .s_in(u_if2), .tx_o(tx2), .busy(busy2), .done(done2)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] word;
    int            acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic rec [NF];
  bit   in_frame = 1'b0;
  bit   rdy_bad, done_bad;
  bit   abort_ok = 1'b0;
  int   aborts = 0;
  int   fcyc;

  function automatic logic model_chip(input logic [DW-1:0] w, input int k);
    int b;
    b = k / RB;
    if (b == 0) return 1'b0;
    if (b == DW + 1) return 1'b1;
    return w[b-1];
  endfunction

  function automatic logic [DW+1:0] vote_frame();
    logic [DW+1:0] v;
    int ones;
    v = '0;
    for (int b = 0; b < DW + 2; b++) begin
      ones = 0;
      for (int r = 0; r < REP; r++) ones += int'(rec[b*RB + r*BD + BD/2]);
      v[b] = (ones > REP / 2);
    end
    return v;
  endfunction

  // Frame monitor: pops the expected word when busy rises, captures the line, judges at the done cycle
  always @(negedge clk) begin
    int bad;
    if (!in_frame && busy === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_frame", 1, 0);
        cur.word = '0;
        cur.acc  = cyc;
      end else begin
        cur = sb.pop_front();
        check("start_latency", cyc, cur.acc);
      end
      in_frame = 1'b1;
      fcyc     = 0;
      rdy_bad  = 1'b0;
      done_bad = 1'b0;
    end
    if (in_frame) begin
      if (fcyc < NF) begin
        if (busy !== 1'b1) begin
          in_frame = 1'b0;
          if (abort_ok) aborts++;
          else check("busy_length", fcyc, NF);
        end else begin
          rec[fcyc] = tx;
          rdy_bad  |= (u_if.in_ready !== 1'b0);
          done_bad |= (done !== 1'b0);
          fcyc++;
        end
      end else begin
        in_frame = 1'b0;
        check("end_busy_done_tx", {busy, done, tx}, 3'b011);
        check("ready_done_low_in_frame", {rdy_bad, done_bad}, 0);
        bad = 0;
        for (int k = 0; k < NF; k++) if (rec[k] !== model_chip(cur.word, k)) bad++;
        check("chip_errors", bad, 0);
        check("majority_frame", vote_frame(), {1'b1, cur.word, 1'b0});
      end
    end else if (done === 1'b1) begin
      check("stray_done", 1, 0);
    end
  end

  logic q2[$];
  int   len2 = 0;

  always @(negedge clk) begin
    logic e;
    if (busy2 === 1'b1) begin
      len2++;
      if (q2.size() == 0) check("deg_extra_chip", 1, 0);
      else begin
        e = q2.pop_front();
        check("deg_chip", tx2, e);
      end
    end
    if (done2 === 1'b1) begin
      check("deg_frame_len", len2, 6);
      check("deg_idle_at_done", {busy2, tx2}, 2'b01);
      check("deg_leftover", q2.size(), 0);
      len2 = 0;
    end
  end

  task automatic send(input logic [DW-1:0] w, input bit hold);
    int t;
    t = 0;
    u_if.in_data  = w;
    u_if.in_valid = 1'b1;
    #1;
    while (u_if.in_ready !== 1'b1) begin
      @(negedge clk);
      #1;
      t++;
      if (t > 500) begin
        check("accept_timeout", t, 0);
        u_if.in_valid = 1'b0;
        return;
      end
    end
    sb.push_back('{w, cyc + 1});
    @(negedge clk);
    if (!hold) u_if.in_valid = 1'b0;
  endtask

  task automatic send2(input logic [DW2-1:0] w);
    int t;
    t = 0;
    u_if2.in_data  = w;
    u_if2.in_valid = 1'b1;
    #1;
    while (u_if2.in_ready !== 1'b1) begin
      @(negedge clk);
      #1;
      t++;
      if (t > 100) begin
        check("deg_accept_timeout", t, 0);
        u_if2.in_valid = 1'b0;
        return;
      end
    end
    q2.push_back(1'b0);
    for (int i = 0; i < DW2; i++) q2.push_back(w[i]);
    q2.push_back(1'b1);
    @(negedge clk);
    u_if2.in_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || in_frame || busy !== 1'b0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("drain_timeout", t, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    logic [DW-1:0] w;
    bit hold;
    rst            = 1'b1;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = 8'h55;
    u_if2.in_valid = 1'b0;
    u_if2.in_data  = '0;

    repeat (3) begin
      @(negedge clk);
      check("reset_state", {u_if.in_ready, tx, busy, done}, 4'b0100);
    end
    rst           = 1'b0;
    u_if.in_valid = 1'b0;
    #1;
    check("ready_after_reset", {u_if.in_ready, tx, busy}, 3'b110);
    @(negedge clk);
    check("idle_after_reset", {tx, busy, done}, 3'b100);

    send(8'hA5, 1'b0);
    wait_idle();

    send(8'h00, 1'b1);
    a1 = cyc;
    send(8'hFF, 1'b0);
    a2 = cyc;
    check("b2b_accept_spacing", a2 - a1, NF + 1);
    wait_idle();

    send(8'h3C, 1'b0);
    repeat (NF - 3) begin
      u_if.in_data  = DW'($urandom);
      u_if.in_valid = 1'b1;
      @(negedge clk);
    end
    u_if.in_valid = 1'b0;
    wait_idle();

    send(DW'($urandom), 1'b0);
    repeat (19) @(negedge clk);
    abort_ok = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    check("abort_reset_state", {u_if.in_ready, tx, busy, done}, 4'b0100);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("abort_quiet", {busy, done, tx}, 3'b001);
    end
    abort_ok = 1'b0;
    check("abort_seen", aborts, 1);

    send(8'h81, 1'b0);
    wait_idle();

    repeat (12) begin
      w    = DW'($urandom);
      hold = 1'($urandom_range(0, 1));
      send(w, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    u_if.in_valid = 1'b0;
    wait_idle();

    send2(4'h6);
    repeat (3) send2(DW2'($urandom));

    check("scoreboard_empty", sb.size(), 0);
    check("deg_queue_empty", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
